// File: rtl/sr_pulse_driver.sv
// Debounced ON/OFF push-buttons to mutually exclusive, fixed-width S/R latch pulses.
// Optional build macro SR_PULSE_DRIVER_SUPPRESS_EN drops presses that would not change q_est.
module sr_pulse_driver #(
  parameter int unsigned DEBOUNCE  = 4,
  parameter int unsigned PULSE_LEN = 2,
  parameter int unsigned GAP_LEN   = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic on_btn,
  input  logic off_btn,
  output logic S,
  output logic R,
  output logic q_est,
  output logic busy,
  output logic conflict
);

  localparam int unsigned DbW = $clog2(DEBOUNCE + 1);
  localparam int unsigned PlW = $clog2(PULSE_LEN + 1);
  localparam int unsigned GpW = $clog2(GAP_LEN + 1);

  typedef enum logic [1:0] {StIdle, StPulseS, StPulseR, StGap} state_t;

  // Bit 0 is the ON button, bit 1 the OFF button.
  logic [1:0]     r_sync1, r_sync2, r_deb, r_deb_prev;
  logic [DbW-1:0] r_db_cnt [2];
  logic [1:0]     w_evt;

  state_t         r_state, w_state_next;
  logic [PlW-1:0] r_pcnt, w_pcnt_next;
  logic [GpW-1:0] r_gcnt, w_gcnt_next;
  logic           r_q, w_q_next;
  logic           r_s, r_r, r_busy, r_conflict;
  logic           w_conflict, w_on_valid, w_off_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1     <= '0;
      r_sync2     <= '0;
      r_deb       <= '0;
      r_deb_prev  <= '0;
      r_db_cnt[0] <= '0;
      r_db_cnt[1] <= '0;
    end else begin
      r_sync1    <= {off_btn, on_btn};
      r_sync2    <= r_sync1;
      r_deb_prev <= r_deb;
      for (int i = 0; i < 2; i++) begin
        if (r_sync2[i] == r_deb[i]) begin
          r_db_cnt[i] <= '0;
        end else if (r_db_cnt[i] == DbW'(DEBOUNCE - 1)) begin
          r_deb[i]    <= r_sync2[i];
          r_db_cnt[i] <= '0;
        end else begin
          r_db_cnt[i] <= r_db_cnt[i] + DbW'(1);
        end
      end
    end
  end

  assign w_evt = r_deb & ~r_deb_prev;

  always_comb begin
    w_state_next = r_state;
    w_pcnt_next  = r_pcnt;
    w_gcnt_next  = r_gcnt;
    w_q_next     = r_q;
    w_conflict   = 1'b0;
`ifdef SR_PULSE_DRIVER_SUPPRESS_EN
    w_on_valid   = w_evt[0] & ~r_q;
    w_off_valid  = w_evt[1] & r_q;
`else
    w_on_valid   = w_evt[0];
    w_off_valid  = w_evt[1];
`endif
    case (r_state)
      StIdle: begin
        // A press while the other button is held never pulses, so S=R=1 stays unreachable.
        if ((w_on_valid && r_deb[1]) || (w_off_valid && r_deb[0])) begin
          w_conflict = 1'b1;
        end else if (w_on_valid) begin
          w_state_next = StPulseS;
          w_pcnt_next  = '0;
          w_q_next     = 1'b1;
        end else if (w_off_valid) begin
          w_state_next = StPulseR;
          w_pcnt_next  = '0;
          w_q_next     = 1'b0;
        end
      end
      StPulseS, StPulseR: begin
        if (r_pcnt == PlW'(PULSE_LEN - 1)) begin
          w_state_next = StGap;
          w_pcnt_next  = '0;
          w_gcnt_next  = '0;
        end else begin
          w_pcnt_next = r_pcnt + PlW'(1);
        end
      end
      StGap: begin
        if (r_gcnt == GpW'(GAP_LEN - 1)) begin
          w_state_next = StIdle;
          w_gcnt_next  = '0;
        end else begin
          w_gcnt_next = r_gcnt + GpW'(1);
        end
      end
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= StIdle;
      r_pcnt     <= '0;
      r_gcnt     <= '0;
      r_q        <= 1'b0;
      r_s        <= 1'b0;
      r_r        <= 1'b0;
      r_busy     <= 1'b0;
      r_conflict <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_pcnt     <= w_pcnt_next;
      r_gcnt     <= w_gcnt_next;
      r_q        <= w_q_next;
      r_s        <= (w_state_next == StPulseS);
      r_r        <= (w_state_next == StPulseR);
      r_busy     <= (w_state_next != StIdle);
      r_conflict <= w_conflict;
    end
  end

  assign S        = r_s;
  assign R        = r_r;
  assign q_est    = r_q;
  assign busy     = r_busy;
  assign conflict = r_conflict;

endmodule

// File: tb/tb_sr_pulse_driver.sv
// Bench for sr_pulse_driver: directed scenarios plus random button runs against a
// timeline model (debounce as a sample window, pulses as absolute end cycles).
module tb_sr_pulse_driver;

  localparam int DB = 4;
  localparam int PL = 2;
  localparam int GL = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic on_btn = 1'b0;
  logic off_btn = 1'b0;
  logic S, R, q_est, busy, conflict;

  int n_checks = 0;
  int n_fail = 0;
  int cnt_s, cnt_r, cnt_conf;

  // Model state: m_n counts rising edges since reset release.
  int m_n, m_kind, m_pulse_end, m_busy_end;
  bit m_deb_on, m_deb_off, m_rose_on, m_rose_off, m_q, m_conf;
  bit h_on[$];
  bit h_off[$];

  sr_pulse_driver #(
    .DEBOUNCE (DB),
    .PULSE_LEN(PL),
    .GAP_LEN  (GL)
  ) u_dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .on_btn  (on_btn),
    .off_btn (off_btn),
    .S       (S),
    .R       (R),
    .q_est   (q_est),
    .busy    (busy),
    .conflict(conflict)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit hist(input int which, input int k);
    if (k < 1) return 1'b0;
    return (which == 0) ? h_on[k-1] : h_off[k-1];
  endfunction

  // Debounced value flips once the DB synchronised samples (raw delayed by 2) all disagree.
  function automatic bit window_flip(input int which, input bit deb);
    for (int j = m_n - 1 - DB; j <= m_n - 2; j++) begin
      if (hist(which, j) == deb) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic model_reset();
    m_n = 0; m_kind = 0; m_pulse_end = 0; m_busy_end = 0;
    m_deb_on = 0; m_deb_off = 0; m_rose_on = 0; m_rose_off = 0; m_q = 0; m_conf = 0;
    h_on.delete();
    h_off.delete();
  endtask

  task automatic model_step(input bit on, input bit off);
    bit v_on, v_off, f_on, f_off;
    m_n++;
    h_on.push_back(on);
    h_off.push_back(off);
    v_on = m_rose_on;
    v_off = m_rose_off;
`ifdef SR_PULSE_DRIVER_SUPPRESS_EN
    if (m_q) v_on = 1'b0;
    if (!m_q) v_off = 1'b0;
`endif
    m_conf = 1'b0;
    if (m_n > m_busy_end) begin
      if ((v_on && m_deb_off) || (v_off && m_deb_on)) begin
        m_conf = 1'b1;
      end else if (v_on || v_off) begin
        m_kind = v_on ? 1 : 2;
        m_q = v_on;
        m_pulse_end = m_n + PL;
        m_busy_end = m_n + PL + GL;
      end
    end
    f_on = window_flip(0, m_deb_on);
    f_off = window_flip(1, m_deb_off);
    m_rose_on = f_on && !m_deb_on;
    m_rose_off = f_off && !m_deb_off;
    if (f_on) m_deb_on = !m_deb_on;
    if (f_off) m_deb_off = !m_deb_off;
  endtask

  task automatic check_outputs();
    check("S", int'(S), int'(m_kind == 1 && m_n < m_pulse_end));
    check("R", int'(R), int'(m_kind == 2 && m_n < m_pulse_end));
    check("busy", int'(busy), int'(m_n < m_busy_end));
    check("q_est", int'(q_est), int'(m_q));
    check("conflict", int'(conflict), int'(m_conf));
  endtask

  // Called at a falling edge; returns at the next falling edge.
  task automatic tick(input bit on, input bit off);
    on_btn = on;
    off_btn = off;
    @(posedge clk);
    model_step(on, off);
    #1;
    check_outputs();
    cnt_s += int'(S);
    cnt_r += int'(R);
    cnt_conf += int'(conflict);
    @(negedge clk);
  endtask

  task automatic do_reset(input bit on, input bit off);
    on_btn = on;
    off_btn = off;
    rst_n = 1'b0;
    model_reset();
    #1;
    check("rst_S", int'(S), 0);
    check_outputs();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic clr_counts();
    cnt_s = 0; cnt_r = 0; cnt_conf = 0;
  endtask

  task automatic run(input bit on, input bit off, input int n);
    for (int i = 0; i < n; i++) tick(on, off);
  endtask

  initial begin
    clr_counts();
    do_reset(1'b0, 1'b0);
    run(1'b0, 1'b0, 20);
    check("idle_activity", cnt_s + cnt_r + cnt_conf, 0);

    // ON held from before the first edge after reset.
    do_reset(1'b1, 1'b0);
    clr_counts();
    for (int k = 1; k <= 12; k++) begin
      tick(1'b1, 1'b0);
      check("hold_S_window", int'(S), int'(k == 7 || k == 8));
      check("hold_busy_window", int'(busy), int'(k >= 7 && k <= 10));
    end
    check("hold_q_est", int'(q_est), 1);
    check("hold_no_R", cnt_r, 0);
    run(1'b0, 1'b0, 12);

    // Bounce shorter than the debounce window.
    clr_counts();
    for (int k = 0; k < 12; k++) tick(bit'((k / 2) % 2 == 0), 1'b0);
    run(1'b0, 1'b0, 12);
    check("bounce_no_S", cnt_s, 0);
    check("bounce_q_est", int'(q_est), 1);

    // OFF pressed while ON is held.
    run(1'b1, 1'b0, 15);
    clr_counts();
    run(1'b1, 1'b1, 12);
    check("held_conflict_cycles", cnt_conf, 1);
    check("held_no_R", cnt_r, 0);
    run(1'b0, 1'b0, 12);

    // Both pressed together.
    clr_counts();
    run(1'b1, 1'b1, 12);
    check("both_conflict_cycles", cnt_conf, 1);
    check("both_no_pulse", cnt_s + cnt_r, 0);
    run(1'b0, 1'b0, 12);

    // Bring q_est to 0, then land an OFF press inside the guard gap.
    run(1'b0, 1'b1, 12);
    run(1'b0, 1'b0, 12);
    check("off_q_est", int'(q_est), 0);
    clr_counts();
    run(1'b1, 1'b0, 2);
    run(1'b1, 1'b1, 2);
    run(1'b0, 1'b1, 8);
    run(1'b0, 1'b0, 12);
    check("gap_S_pulse", cnt_s, PL);
    check("gap_no_R", cnt_r, 0);
    check("gap_q_est", int'(q_est), 1);

    // Redundant ON press with q_est already 1.
    clr_counts();
    run(1'b1, 1'b0, 12);
    run(1'b0, 1'b0, 12);
`ifdef SR_PULSE_DRIVER_SUPPRESS_EN
    check("redundant_S", cnt_s, 0);
    check("redundant_busy", int'(busy), 0);
`else
    check("redundant_S", cnt_s, PL);
`endif

    // Reset during PULSE_S with the button still held.
    do_reset(1'b0, 1'b0);
    run(1'b1, 1'b0, 7);
    check("pre_rst_S", int'(S), 1);
    #2;
    do_reset(1'b1, 1'b0);
    check("rst_q_est", int'(q_est), 0);
    clr_counts();
    run(1'b1, 1'b0, 12);
    check("rst_fresh_press_S", cnt_s, PL);
    run(1'b0, 1'b0, 12);

    // Random button runs with occasional resets.
    for (int seg = 0; seg < 250; seg++) begin
      int unsigned pat, len;
      pat = $urandom_range(0, 3);
      len = $urandom_range(1, 10);
      if ($urandom_range(0, 29) == 0) do_reset(pat[0], pat[1]);
      run(pat[0], pat[1], int'(len));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
